// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared opcode encoding, FSM state type and latency helpers
//                for the multiply/divide sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Opcodes shared with the md datapath
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MTLO  = 4'd1;
    localparam logic [3:0] OP_MTHI  = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_MULTU = 4'd5;
    localparam logic [3:0] OP_MULT  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MFHI  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;

    // Controller state: RUN exactly while the latency counter is non-zero
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Counter width: enough bits for the longer latency, plus one
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int longest;
        longest = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return $clog2(longest) + 1;
    endfunction

    // Multi-cycle operations that occupy the unit
    function automatic logic is_long(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_DIV) || (op == OP_MULTU) ||
               (op == OP_MULT) || (op == OP_MADD);
    endfunction

    // Single-cycle HI/LO moves
    function automatic logic is_mt(input logic [3:0] op);
        return (op == OP_MTLO) || (op == OP_MTHI);
    endfunction

    // Busy cycles for a long op; divides take the divide latency
    function automatic int latency(input logic [3:0] op, input int mul_cycles,
                                   input int div_cycles);
        return ((op == OP_DIVU) || (op == OP_DIV)) ? div_cycles : mul_cycles;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_lat_counter
//  Description : Loadable down-counter with terminal-count flag (count == 1)
//                and synchronous clear. Stops at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_lat_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] r_cnt;

    // Clear beats load, load beats decrement; an empty counter stays at zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign tc = (r_cnt == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_ctrl
//  Description : Sequencing controller for the execute-stage multiply/divide
//                unit. Launches long ops, tracks their fixed latency, stalls
//                decode while busy, strobes the HI/LO commit at completion
//                and cancels in-flight work on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op_d,
    input  logic [3:0]  op_e,
    input  logic [31:0] num_a,
    input  logic [31:0] num_b,
    input  logic        flush,
    output logic        xstall,
    output logic        busy,
    output logic [3:0]  dp_op,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic        hilo_we,
    output logic        mt_we,
    output logic        cancelled,
    output logic        err
);

    localparam int c_CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    md_state_t          r_state;
    logic [3:0]         r_dp_op;
    logic [31:0]        r_dp_a;
    logic [31:0]        r_dp_b;
    logic               r_cancelled;
    logic               r_err;

    logic               w_busy;
    logic               w_tc;
    logic               w_long_op;
    logic               w_mt_op;
    logic               w_launch;
    logic               w_clear;
    logic [c_CNT_W-1:0] w_load_val;

    assign w_busy     = (r_state == ST_RUN);
    assign w_long_op  = is_long(op_e);
    assign w_mt_op    = is_mt(op_e);
    assign w_launch   = !w_busy && w_long_op && !flush;
    assign w_clear    = flush;
    assign w_load_val = c_CNT_W'(latency(op_e, MUL_CYCLES, DIV_CYCLES));

    md_lat_counter #(
        .WIDTH    (c_CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .load     (w_launch),
        .load_val (w_load_val),
        .tc       (w_tc)
    );

    // Controller FSM with operand capture, cancel pulse and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_dp_op     <= OP_NONE;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_cancelled <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cancelled <= w_busy && flush;
            if (w_busy && !flush && (w_long_op || w_mt_op)) begin
                r_err <= 1'b1;
            end
            if (r_state == ST_IDLE) begin
                if (w_launch) begin
                    r_state <= ST_RUN;
                    r_dp_op <= op_e;
                    r_dp_a  <= num_a;
                    r_dp_b  <= num_b;
                end
            end else begin
                // Flush or the last counted cycle both end the run
                if (flush || w_tc) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    // Conservative stall: any md op in decode waits while the unit is busy
    assign xstall    = w_busy && (op_d != OP_NONE);
    assign busy      = w_busy;
    assign hilo_we   = w_busy && w_tc && !flush;
    assign mt_we     = !w_busy && w_mt_op && !flush;
    assign dp_op     = r_dp_op;
    assign dp_a      = r_dp_a;
    assign dp_b      = r_dp_b;
    assign cancelled = r_cancelled;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_ctrl
//  Description : Self-checking bench for md_ctrl: behavioural model compared
//                every cycle plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op_d;
    logic [3:0]  op_e;
    logic [31:0] num_a;
    logic [31:0] num_b;
    logic        flush;
    logic        xstall;
    logic        busy;
    logic [3:0]  dp_op;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic        hilo_we;
    logic        mt_we;
    logic        cancelled;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    md_ctrl #(
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_d      (op_d),
        .op_e      (op_e),
        .num_a     (num_a),
        .num_b     (num_b),
        .flush     (flush),
        .xstall    (xstall),
        .busy      (busy),
        .dp_op     (dp_op),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .hilo_we   (hilo_we),
        .mt_we     (mt_we),
        .cancelled (cancelled),
        .err       (err)
    );

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_rem   = 0;
    logic [3:0]  m_op    = 4'd0;
    logic [31:0] m_a     = 32'd0;
    logic [31:0] m_b     = 32'd0;
    logic        m_err   = 1'b0;
    logic        m_canc  = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_was_busy;
    logic        e_busy;

    function automatic int m_lat(input logic [3:0] op);
        if (op == 4'd3 || op == 4'd4) return 10;
        if (op == 4'd5 || op == 4'd6 || op == 4'd9) return 5;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_rem  = 0;
            m_op   = 4'd0;
            m_a    = 32'd0;
            m_b    = 32'd0;
            m_err  = 1'b0;
            m_canc = 1'b0;
        end else begin
            m_was_busy = (m_rem > 0);
            m_canc = m_was_busy && flush;
            if (m_was_busy && !flush && (m_lat(op_e) > 0 || op_e == 4'd1 || op_e == 4'd2))
                m_err = 1'b1;
            if (m_was_busy) begin
                m_rem = flush ? 0 : m_rem - 1;
            end else if (!flush && m_lat(op_e) > 0) begin
                m_rem = m_lat(op_e);
                m_op  = op_e;
                m_a   = num_a;
                m_b   = num_b;
            end
        end
        m_ready = 1'b1;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_ready) begin
            e_busy = (m_rem > 0);
            check_bit("busy", busy, e_busy);
            check_bit("xstall", xstall, e_busy && (op_d != 4'd0));
            check_bit("hilo_we", hilo_we, (m_rem == 1) && !flush);
            check_bit("mt_we", mt_we, !e_busy && !flush && (op_e == 4'd1 || op_e == 4'd2));
            check_bit("cancelled", cancelled, m_canc);
            check_bit("err", err, m_err);
            check_word("dp_op", {28'd0, dp_op}, {28'd0, m_op});
            check_word("dp_a", dp_a, m_a);
            check_word("dp_b", dp_b, m_b);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    int nx;
    int nh;

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        reset = 1'b1; op_d = 4'd0; op_e = 4'd0; num_a = 32'd0; num_b = 32'd0; flush = 1'b0;
        tick;
        at_neg;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_word("rst_dp_a", dp_a, 32'd0);
        tick;
        reset = 1'b0;
        tick;

        // mult 3*4: busy cycles 0..4, commit in cycle 4
        op_e = 4'd6; num_a = 32'd3; num_b = 32'd4;
        tick;
        op_e = 4'd0; num_a = 32'hdead; num_b = 32'hbeef;
        for (int i = 0; i < 6; i++) begin
            at_neg;
            check_bit("t1_busy", busy, (i < 5));
            check_bit("t1_hilo", hilo_we, (i == 4));
            tick;
        end
        check_word("t1_dp_a", dp_a, 32'd3);
        check_word("t1_dp_b", dp_b, 32'd4);
        check_word("t1_dp_op", {28'd0, dp_op}, 32'd6);

        // div with mflo held in decode: 10 stall cycles, one commit
        op_d = 4'd7; op_e = 4'd4; num_a = 32'd100; num_b = 32'd7;
        tick;
        op_e = 4'd0;
        nx = 0; nh = 0;
        for (int i = 0; i < 12; i++) begin
            at_neg;
            nx += int'(xstall);
            nh += int'(hilo_we);
            if (i == 9)  check_bit("t2_xstall_last", xstall, 1'b1);
            if (i == 10) check_bit("t2_xstall_off", xstall, 1'b0);
            tick;
        end
        check_word("t2_xstall_cycles", nx, 32'd10);
        check_word("t2_hilo_count", nh, 32'd1);
        op_d = 4'd0;

        // mult flushed in cycle 2
        op_e = 4'd6;
        tick;
        op_e = 4'd0;
        nh = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) flush = 1'b1;
            at_neg;
            nh += int'(hilo_we);
            if (i == 2) check_bit("t3_busy_c2", busy, 1'b1);
            if (i == 3) begin
                check_bit("t3_busy_c3", busy, 1'b0);
                check_bit("t3_cancel_c3", cancelled, 1'b1);
            end
            if (i == 4) check_bit("t3_cancel_c4", cancelled, 1'b0);
            tick;
            flush = 1'b0;
        end
        check_word("t3_hilo_count", nh, 32'd0);

        // flush coincident with the final counted cycle
        op_e = 4'd5;
        tick;
        op_e = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) flush = 1'b1;
            at_neg;
            if (i == 4) check_bit("t4_hilo_flush", hilo_we, 1'b0);
            if (i == 5) begin
                check_bit("t4_cancel", cancelled, 1'b1);
                check_bit("t4_busy", busy, 1'b0);
            end
            tick;
            flush = 1'b0;
        end
        // flush with a launch in IDLE
        flush = 1'b1; op_e = 4'd5;
        at_neg;
        check_bit("t4_idle_busy", busy, 1'b0);
        tick;
        flush = 1'b0; op_e = 4'd0;
        at_neg;
        check_bit("t4_no_launch", busy, 1'b0);
        check_bit("t4_no_cancel", cancelled, 1'b0);
        tick;

        // moves and launches while busy
        op_e = 4'd6; num_a = 32'd11; num_b = 32'd12;
        tick;
        op_e = 4'd2;
        at_neg;
        check_bit("t5_mt_busy", mt_we, 1'b0);
        tick;
        op_e = 4'd9; num_a = 32'd77;
        at_neg;
        check_bit("t5_err_set", err, 1'b1);
        tick;
        op_e = 4'd0;
        repeat (5) tick;
        at_neg;
        check_bit("t5_err_held", err, 1'b1);
        check_word("t5_dp_a_kept", dp_a, 32'd11);
        check_word("t5_dp_op_kept", {28'd0, dp_op}, 32'd6);
        tick;
        op_e = 4'd1;
        at_neg;
        check_bit("t5_mt_idle", mt_we, 1'b1);
        tick;
        op_e = 4'd0;
        at_neg;
        check_bit("t5_mt_done", mt_we, 1'b0);
        tick;

        // reset during a div in cycle 6
        op_e = 4'd4; num_a = 32'd5; num_b = 32'd6;
        tick;
        op_e = 4'd0;
        repeat (6) tick;
        reset = 1'b1;
        at_neg;
        check_bit("t6_busy_pre", busy, 1'b1);
        tick;
        reset = 1'b0;
        at_neg;
        check_bit("t6_busy", busy, 1'b0);
        check_bit("t6_err", err, 1'b0);
        check_bit("t6_cancel", cancelled, 1'b0);
        check_word("t6_dp_a", dp_a, 32'd0);
        check_word("t6_dp_op", {28'd0, dp_op}, 32'd0);
        tick;

        // full mult after reset, then back-to-back madd
        op_e = 4'd6; num_a = 32'd8; num_b = 32'd9;
        tick;
        op_e = 4'd0;
        for (int i = 0; i < 5; i++) begin
            at_neg;
            check_bit("t6_mult_busy", busy, 1'b1);
            check_bit("t6_mult_hilo", hilo_we, (i == 4));
            tick;
        end
        op_e = 4'd9; num_a = 32'd1;
        at_neg;
        check_bit("t6_idle_gap", busy, 1'b0);
        tick;
        op_e = 4'd0;
        at_neg;
        check_bit("t6_b2b_busy", busy, 1'b1);
        check_word("t6_b2b_op", {28'd0, dp_op}, 32'd9);
        tick;
        repeat (6) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_ctrl.md
# md_ctrl

Sequencing controller for the execute-stage multiply/divide unit. It launches mult/multu/madd/div/divu operations, tracks their fixed latency with a down-counter, and raises a decode-stage stall while an operation is in flight. It commits the HI/LO result only at completion, and cancels in-flight work on pipeline flush. It sits between the decode/execute control path and the HI/LO datapath, which becomes a pure compute-and-write slave.

## Interface
- MUL_CYCLES, 5, busy cycles for mult/multu/madd (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- op_d  in  4  md opcode in decode stage
- op_e  in  4  md opcode in execute stage
- num_a  in  32  execute-stage operand A
- num_b  in  32  execute-stage operand B
- flush  in  1  cancel in-flight op and any op_e launch this cycle
- xstall  out  1  stall decode
- busy  out  1  operation in flight
- dp_op  out  4  opcode held for datapath
- dp_a, dp_b  out  32 each  latched operands
- hilo_we  out  1  datapath commits HI/LO this cycle
- mt_we  out  1  mthi/mtlo write strobe, same cycle as op_e
- cancelled  out  1  one-cycle pulse after a flush kills an op
- err  out  1  sticky: launch attempted while busy

## Operation
- Opcodes (shared with the md datapath): 0 none, 1 mtlo, 2 mthi, 3 divu, 4 div, 5 multu, 6 mult, 7 mflo, 8 mfhi, 9 madd. Long ops = {3,4,5,6,9}. All of 1..9 are md ops.
- FSM states:
  - IDLE: cnt = 0.
  - RUN: cnt > 0.
  - busy = (state == RUN).
- IDLE, op_e long, no flush → RUN:
  - latch dp_op = op_e, dp_a = num_a, dp_b = num_b;
  - cnt = MUL_CYCLES or DIV_CYCLES by op.
- RUN: cnt decrements each edge. hilo_we = (cnt == 1) && !flush. On the edge where cnt == 1, cnt → 0 and the FSM returns to IDLE.
- op_e ∈ {1,2}: mt_we = 1 combinationally, only if !busy && !flush. No state change.
- op_e ∈ {7,8}: no action. Reads are served by the datapath.
- xstall = busy && op_d ≠ 0 && !(cnt == 1 && op_d ∈ {7,8} would be safe). The exclusion is not applied: xstall is simply busy && op_d ≠ 0. A one-cycle conservative stall is accepted.
- Launch while busy (op_e long, or op_e ∈ {1,2}, in RUN):
  - ignored;
  - err set, held until reset;
  - the current op continues.
- flush in RUN: cnt → 0, IDLE. No hilo_we that cycle (even if cnt == 1). cancelled = 1 the next cycle.
- flush in IDLE: suppresses any launch or mt_we. cancelled stays 0.
- dp_op, dp_a, dp_b hold their values until the next launch, and are not cleared at completion.

## Timing
- Reset values: busy 0, xstall 0, hilo_we 0, mt_we 0, cancelled 0, err 0, dp_op 0, dp_a 0, dp_b 0, cnt 0, IDLE.
- Launch at edge T:
  - busy = 1 for exactly N cycles (T..T+N-1);
  - hilo_we is high in cycle T+N-1 only;
  - busy = 0 from cycle T+N.
- A back-to-back launch is legal in cycle T+N: op_e long while IDLE.
- Reset mid-RUN returns all outputs to their reset values on the next edge. No hilo_we.
- Simultaneous flush and cnt == 1: flush wins.
- Simultaneous reset and flush: reset wins; cancelled = 0.
- All outputs are registered state or combinational on (state, cnt, op_d, op_e, flush). There is no combinational path from num_a/num_b to any output other than via registers.

## Structure
- Package md_pkg:
  - opcode constants (OP_NONE … OP_MADD);
  - is_long and latency helper function;
  - FSM state enum;
  - counter width (clog2 of the larger latency, plus 1).
- One natural sub-module, md_lat_counter: loadable down-counter with a terminal-count flag and a synchronous clear. md_ctrl instantiates it once.

## Test plan
- Reset, then op_e = 6 for one cycle with a = 3, b = 4 → busy high for cycles 0..4, hilo_we only in cycle 4, dp_a = 3, dp_b = 4, busy low in cycle 5.
- op_e = 4 (div), with op_d = 7 held for the whole run → xstall high for exactly 10 cycles, then low; hilo_we once.
- mult launched, then flush asserted in cycle 2 → busy low from cycle 3, hilo_we never pulses, cancelled pulses in cycle 3.
- flush in the same cycle as cnt == 1 → no hilo_we, cancelled = 1 the next cycle. Also: flush coincident with op_e = 5 in IDLE → no launch, busy stays 0.
- op_e = 2 while busy → mt_we = 0, err = 1 and held. op_e = 1 while IDLE → mt_we = 1 for one cycle.
- reset asserted mid-div, cycle 6 → all outputs return to their reset values next edge. A later mult runs the full 5 cycles correctly.
